alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are even and at least 8.
REQ-002 Parameter CNT_W, default 6: iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Flush  input  1  synchronous abort of any in-flight operation.
REQ-006 In_valid  input  1  operands and Code present.
REQ-007 In_ready  output  1  unit can accept an operation.
REQ-008 A  input  WIDTH  operand rs1 / dividend.
REQ-009 B  input  WIDTH  operand rs2 / divisor.
REQ-010 Code  input  3  operation: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU, 4=DIV, 5=DIVU, 6=REM, 7=REMU.
REQ-011 Out_valid  output  1  result C is valid.
REQ-012 Out_ready  input  1  consumer accepts C.
REQ-013 C  output  WIDTH  result.
REQ-014 Busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, CALC, DONE; In_ready SHALL be high only in IDLE.
REQ-016 Accept event: IDLE, In_valid=1 and Flush=0 at a rising edge; on it A, B and Code are registered, and the operands are converted to magnitudes per the signedness implied by Code.
REQ-017 Normal path: state goes IDLE->CALC on accept; CALC runs exactly WIDTH iterations, one per cycle, counter 0..WIDTH-1; on the last iteration it goes to DONE.
REQ-018 Normal-path latency: Out_valid SHALL rise exactly WIDTH+1 rising edges after the accept edge.
REQ-019 Multiply: radix-2 shift-add on magnitudes into a 2*WIDTH product; the product is negated when the operand signs differ (signed operands only).
REQ-020 MUL returns product[WIDTH-1:0]; MULH, MULHSU and MULHU return product[2*WIDTH-1:WIDTH].
REQ-021 MULHSU treats A as signed and B as unsigned.
REQ-022 Divide: restoring division on magnitudes.
REQ-023 Signed quotient is negated when the operand signs differ.
REQ-024 Signed remainder takes the sign of the dividend.
REQ-025 Divide by zero (B=0, any DIV/REM code): no iterations; IDLE->DONE; quotient = all ones; remainder = A.
REQ-026 Signed overflow (DIV/REM, A = most negative, B = all ones): no iterations; IDLE->DONE; quotient = A; remainder = 0.
REQ-027 Special-case latency: Out_valid SHALL rise one edge after the accept edge.
REQ-028 DONE: Out_valid=1 and C held stable until Out_valid and Out_ready are both high at a rising edge, then state goes DONE->IDLE.
REQ-029 Back-to-back: the next accept is possible no earlier than the edge after the IDLE return.
REQ-030 Out_ready is ignored outside DONE.
REQ-031 In_valid is ignored outside IDLE; operand changes during CALC SHALL NOT affect the result.
REQ-032 Flush=1 at a rising edge forces IDLE from any state, clears Out_valid, and discards the operation.
REQ-033 Flush has priority over accept and over the output handshake on the same edge.
REQ-034 C SHALL read 0 whenever Out_valid=0.

Reset
REQ-035 While Reset=1: state=IDLE, counter=0, all datapath registers 0, Out_valid=0, Busy=0, C=0; In_ready SHALL read 1.
REQ-036 Reset asserted mid-CALC or in DONE SHALL abort the operation with no output handshake.
REQ-037 The first accept is possible on the first rising edge after Reset deasserts.

Verification (WIDTH=32)
REQ-038 MUL A=0xFFFFFFFF (-1), B=7 -> C=0xFFFFFFF9; MULH with the same operands -> C=0xFFFFFFFF; MULHU -> C=0x00000006; each with Out_valid exactly 33 edges after accept.
REQ-039 DIV A=-7, B=2 -> C=0xFFFFFFFD (-3); REM with the same operands -> C=0xFFFFFFFF (-1); DIVU A=100, B=7 -> C=14; REMU with the same operands -> C=2.
REQ-040 DIVU A=0x12345678, B=0 -> C=0xFFFFFFFF; REMU with the same operands -> C=0x12345678; DIV A=0x80000000, B=0xFFFFFFFF -> C=0x80000000; REM with the same operands -> C=0; each with Out_valid one edge after accept.
REQ-041 Hold Out_ready=0 for 10 cycles in DONE -> C stable, Out_valid held, In_ready=0, a new In_valid is ignored; then raise Out_ready -> IDLE on that edge.
REQ-042 Assert Flush at CALC iteration 15 -> next cycle IDLE, Out_valid never asserted; an immediately following MULHSU A=-2, B=3 -> C=0xFFFFFFFF.
REQ-043 Assert Reset asynchronously mid-CALC -> outputs reach their reset values without a clock edge; after release, a new MUL 3*5 -> C=15.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with the result sign fixed up afterwards.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_code,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_c,
  output logic             o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_code;
  logic               r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_c;

  logic               w_accept, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic               w_div0, w_ovf, w_last;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_result;
  logic [WIDTH:0]     w_mul_sum, w_trial;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;

  // Operand signedness by code: MUL/MULH/DIV/REM signed both, MULHSU signed A only.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (i_code)
      3'd0, 3'd1, 3'd4, 3'd6: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'd2:                   w_a_sgn = 1'b1;
      default:                ;
    endcase
  end

  assign w_is_div = i_code[2];
  assign w_a_neg  = w_a_sgn & i_a[WIDTH-1];
  assign w_b_neg  = w_b_sgn & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;
  assign w_div0   = w_is_div & (i_b == '0);
  assign w_ovf    = w_is_div & ~i_code[0] & (i_a == {1'b1, {(WIDTH-1){1'b0}}}) & (i_b == '1);
  assign w_accept = (r_state == S_IDLE) & i_in_valid & ~i_flush;
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, dividend/quotient}.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
  assign w_div_nxt = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                    : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_result = '0;
    case (r_code)
      3'd0:             w_result = w_prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: w_result = w_prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       w_result = w_quo;
      default:          w_result = w_rem;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (w_div0 | w_ovf) ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (r_out_valid & i_out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Special cases preload acc so the common result mux yields them with no sign fix-up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_code  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_code <= i_code;
      r_cnt  <= '0;
      if (w_div0) begin
        r_acc   <= {i_a, {WIDTH{1'b1}}};
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_acc   <= {{WIDTH{1'b0}}, i_a};
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_is_div) begin
        r_opnd  <= w_b_mag;
        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else begin
        r_opnd  <= w_a_mag;
        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_acc <= r_code[2] ? w_div_nxt : w_mul_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The result is registered on the first DONE cycle, so valid trails DONE entry by one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_c         <= '0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
      r_c         <= '0;
    end else if ((r_state == S_DONE) && !r_out_valid) begin
      r_out_valid <= 1'b1;
      r_c         <= w_result;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
      r_c         <= '0;
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_c         = r_c;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (WIDTH=32): vector table plus hold, flush and reset sequences.
module tb_alu_muldiv;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic [2:0]  i_code = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [31:0] o_c;
  logic        o_busy;

  int tests = 0;
  int fails = 0;

  alu_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .i_a(i_a), .i_b(i_b), .i_code(i_code),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_c(o_c), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full transaction; operands are scrambled right after the accept edge.
  task automatic run_op(input string nm, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(negedge i_clk);
    i_code = code; i_a = a; i_b = b; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    i_a = ~a; i_b = b ^ 32'h5A5A_0001; i_code = ~code;
    check({nm, " busy"}, {63'd0, o_busy}, 64'd1);
    n = 0;
    while (!o_out_valid && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " result"}, {32'd0, o_c}, {32'd0, exp});
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
    check({nm, " idle after handshake"}, {62'd0, o_in_ready, o_out_valid}, 64'd2);
    check({nm, " C zero after handshake"}, {32'd0, o_c}, 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    vecs[0]  = '{"MUL -1*7",       3'd0, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFF9, 33};
    vecs[1]  = '{"MULH -1*7",      3'd1, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 33};
    vecs[2]  = '{"MULHU ffffffff*7",3'd3, 32'hFFFFFFFF, 32'd7,       32'h00000006, 33};
    vecs[3]  = '{"DIV -7/2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[4]  = '{"REM -7/2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[5]  = '{"DIVU 100/7",     3'd5, 32'd100,      32'd7,        32'd14,       33};
    vecs[6]  = '{"REMU 100/7",     3'd7, 32'd100,      32'd7,        32'd2,        33};
    vecs[7]  = '{"DIVU by zero",   3'd5, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1};
    vecs[8]  = '{"REMU by zero",   3'd7, 32'h12345678, 32'd0,        32'h12345678, 1};
    vecs[9]  = '{"DIV overflow",   3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[10] = '{"REM overflow",   3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[11] = '{"DIV by zero",    3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};
    vecs[12] = '{"REM by zero",    3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
    vecs[13] = '{"DIV 7/-2",       3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[14] = '{"REM 7/-2",       3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33};
    vecs[15] = '{"MULH min*min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[16] = '{"MULHSU -1*ffffffff",3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[17] = '{"MULHU 80000000*2",3'd3, 32'h80000000, 32'd2,       32'h00000001, 33};
    vecs[18] = '{"DIV -100/7",     3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33};
    vecs[19] = '{"REMU ffffffff/16",3'd7, 32'hFFFFFFFF, 32'd16,      32'h0000000F, 33};

    #2;
    check("reset outputs", {o_in_ready, o_busy, o_out_valid, 29'd0, o_c}, {1'b1, 63'd0});
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < 20; i++)
      run_op(vecs[i].name, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Hold the result in DONE while a new request is presented.
    @(negedge i_clk);
    i_code = 3'd5; i_a = 32'd100; i_b = 32'd7; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    n = 0;
    while (!o_out_valid && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("hold latency", 64'(n), 64'd33);
    i_code = 3'd0; i_a = 32'd9; i_b = 32'd9; i_in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      check("hold state", {o_c, 29'd0, o_out_valid, o_in_ready, o_busy}, {32'd14, 29'd0, 3'b101});
    end
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
    check("hold release", {61'd0, o_busy, o_out_valid, o_in_ready}, 64'd1);
    repeat (3) @(posedge i_clk);
    #1 check("no stray op after hold", {62'd0, o_busy, o_out_valid}, 64'd0);

    // Flush at iteration 15 of a multiply.
    @(negedge i_clk);
    i_code = 3'd0; i_a = 32'd1234; i_b = 32'd5678; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    repeat (15) @(posedge i_clk);
    @(negedge i_clk);
    check("busy before flush", {63'd0, o_busy}, 64'd1);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    check("flush to idle", {61'd0, o_busy, o_out_valid, o_in_ready}, 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (o_out_valid) seen++;
    end
    check("no valid after flush", 64'(seen), 64'd0);
    run_op("MULHSU -2*3", 3'd2, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33);

    // Asynchronous reset mid-CALC.
    @(negedge i_clk);
    i_code = 3'd1; i_a = 32'hDEADBEEF; i_b = 32'h0BADF00D; i_in_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #2;
    check("busy before reset", {63'd0, o_busy}, 64'd1);
    i_rst = 1'b1;
    #1;
    check("async reset outputs", {o_in_ready, o_busy, o_out_valid, 29'd0, o_c}, {1'b1, 63'd0});
    @(negedge i_clk);
    i_rst = 1'b0;
    run_op("MUL 3*5 after reset", 3'd0, 32'd3, 32'd5, 32'd15, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
